// File: rtl/sp_ram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between NUM_REQ requesters, with bounded burst lock.
// Optional performance counters are compiled in when SP_RAM_ARB_PERF_EN is defined.
module sp_ram_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int WREQ_W    = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_en,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*WREQ_W-1:0] req_W_req,
    input  logic [NUM_REQ*DATA_W-1:0] req_W_data,
    output logic [NUM_REQ-1:0]        req_gnt,
    output logic [NUM_REQ-1:0]        req_rvalid,
    output logic [DATA_W-1:0]         req_R_data,
    output logic                      mem_en,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [WREQ_W-1:0]         mem_W_req,
    output logic [DATA_W-1:0]         mem_W_data,
    input  logic [DATA_W-1:0]         mem_R_data
`ifdef SP_RAM_ARB_PERF_EN
    ,
    input  logic                      perf_clr,
    output logic [NUM_REQ*32-1:0]     perf_stall,
    output logic [31:0]               perf_busy
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {ARB, LOCK} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
    logic [ADDR_W-1:0]  lastAddr_q, lastAddr_d;
    logic [DATA_W-1:0]  lastWData_q, lastWData_d;

    logic               arbFound;
    logic [PTR_W-1:0]   arbWinner;
    int                 arbIdx;
    logic               lockHold;
    logic               gntValid;
    logic [PTR_W-1:0]   gntIdx;

    // Rotating priority search starting at ptr_q; also used on owner release so there is no bubble.
    always_comb begin
        arbFound  = 1'b0;
        arbWinner = '0;
        arbIdx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            arbIdx = int'(ptr_q) + k;
            if (arbIdx >= NUM_REQ) arbIdx = arbIdx - NUM_REQ;
            if (!arbFound && req_en[arbIdx]) begin
                arbFound  = 1'b1;
                arbWinner = PTR_W'(arbIdx);
            end
        end
    end

    always_comb begin
        lockHold = (state_q == LOCK) && req_en[owner_q];
        gntIdx   = lockHold ? owner_q : arbWinner;
        gntValid = !rst && (lockHold || arbFound);
        req_gnt  = '0;
        if (gntValid) req_gnt[gntIdx] = 1'b1;

        mem_en     = gntValid;
        mem_addr   = lastAddr_q;
        mem_W_req  = '1;
        mem_W_data = lastWData_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_gnt[i]) begin
                mem_addr   = req_addr[i*ADDR_W +: ADDR_W];
                mem_W_req  = req_W_req[i*WREQ_W +: WREQ_W];
                mem_W_data = req_W_data[i*DATA_W +: DATA_W];
            end
        end
        req_R_data = mem_R_data;
        req_rvalid = rvalid_q;
    end

    // Next-state: a held lock counts toward MAX_BURST; otherwise the arbitration winner may open a new lock.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        if (lockHold) begin
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
            if (!req_lock[owner_q] || (burst_cnt_q + CNT_W'(1)) == CNT_W'(MAX_BURST)) begin
                state_d     = ARB;
                burst_cnt_d = '0;
            end
        end else if (arbFound) begin
            ptr_d = (arbWinner == PTR_W'(NUM_REQ - 1)) ? '0 : arbWinner + PTR_W'(1);
            if (req_lock[arbWinner] && (MAX_BURST > 1)) begin
                state_d     = LOCK;
                owner_d     = arbWinner;
                burst_cnt_d = CNT_W'(1);
            end else begin
                state_d     = ARB;
                burst_cnt_d = '0;
            end
        end else begin
            state_d     = ARB;
            burst_cnt_d = '0;
        end

        rvalid_d    = (gntValid && (mem_W_req == '1)) ? req_gnt : '0;
        lastAddr_d  = mem_addr;
        lastWData_d = mem_W_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB;
            ptr_q       <= '0;
            owner_q     <= '0;
            burst_cnt_q <= '0;
            rvalid_q    <= '0;
            lastAddr_q  <= '0;
            lastWData_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            rvalid_q    <= rvalid_d;
            lastAddr_q  <= lastAddr_d;
            lastWData_q <= lastWData_d;
        end
    end

`ifdef SP_RAM_ARB_PERF_EN
    logic [31:0] stall_q [NUM_REQ];
    logic [31:0] busy_q;

    // Saturating counters; a clear wins over any increment in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || perf_clr) begin
            for (int i = 0; i < NUM_REQ; i++) stall_q[i] <= '0;
            busy_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_en[i] && !req_gnt[i] && (stall_q[i] != '1)) stall_q[i] <= stall_q[i] + 32'd1;
            end
            if (mem_en && (busy_q != '1)) busy_q <= busy_q + 32'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) perf_stall[i*32 +: 32] = stall_q[i];
        perf_busy = busy_q;
    end
`endif

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed self-checking bench for sp_ram_arbiter (default build, 3 requesters, MAX_BURST=16).
module tb_sp_ram_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  reqEn;
    logic [2:0]  reqLock;
    logic [47:0] reqAddr;
    logic [11:0] reqWReq;
    logic [95:0] reqWData;
    logic [2:0]  reqGnt;
    logic [2:0]  reqRvalid;
    logic [31:0] reqRData;
    logic        memEn;
    logic [15:0] memAddr;
    logic [3:0]  memWReq;
    logic [31:0] memWData;
    logic [31:0] memRData;

    int testsRun;
    int testsFailed;

    sp_ram_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_en     (reqEn),
        .req_lock   (reqLock),
        .req_addr   (reqAddr),
        .req_W_req  (reqWReq),
        .req_W_data (reqWData),
        .req_gnt    (reqGnt),
        .req_rvalid (reqRvalid),
        .req_R_data (reqRData),
        .mem_en     (memEn),
        .mem_addr   (memAddr),
        .mem_W_req  (memWReq),
        .mem_W_data (memWData),
        .mem_R_data (memRData)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM stand-in: read data is a recognisable tag of the address read in the previous cycle.
    always @(posedge clk) begin
        if (memEn && memWReq == 4'hF) memRData <= {16'hDEAD, memAddr};
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst     = 1'b1;
        reqEn   = 3'b000;
        reqLock = 3'b000;
        nextCycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        reqEn = 3'b000;
        nextCycle();
        nextCycle();
        reqEn = 3'b111;
        #4;
        testsRun++;
        if (reqGnt !== 3'b000) begin
            testsFailed++;
            $display("[TB] FAIL reset_gnt: got %b expected %b", reqGnt, 3'b000);
        end
        testsRun++;
        if (memEn !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_mem_en: got %b expected 0", memEn);
        end
        testsRun++;
        if (memWReq !== 4'hF) begin
            testsFailed++;
            $display("[TB] FAIL reset_w_req: got %h expected f", memWReq);
        end
        nextCycle();
        testsRun++;
        if (reqRvalid !== 3'b000) begin
            testsFailed++;
            $display("[TB] FAIL reset_rvalid: got %b expected %b", reqRvalid, 3'b000);
        end
        reqEn = 3'b000;
        rst   = 1'b0;
    endtask

    task automatic test_single();
        reqAddr[16 +: 16] = 16'h0040;
        reqWReq[4 +: 4]   = 4'hF;
        reqEn = 3'b010;
        #4;
        testsRun++;
        if (reqGnt !== 3'b010 || memEn !== 1'b1 || memAddr !== 16'h0040 || memWReq !== 4'hF) begin
            testsFailed++;
            $display("[TB] FAIL single_read_issue: gnt=%b en=%b addr=%h wreq=%h expected 010 1 0040 f",
                     reqGnt, memEn, memAddr, memWReq);
        end
        nextCycle();
        reqEn = 3'b000;
        testsRun++;
        if (reqRvalid !== 3'b010 || reqRData !== 32'hDEAD0040) begin
            testsFailed++;
            $display("[TB] FAIL single_read_data: rvalid=%b data=%h expected 010 dead0040", reqRvalid, reqRData);
        end
        #4;
        testsRun++;
        if (reqGnt !== 3'b000 || memEn !== 1'b0 || memAddr !== 16'h0040 || memWReq !== 4'hF) begin
            testsFailed++;
            $display("[TB] FAIL single_idle_hold: gnt=%b en=%b addr=%h wreq=%h expected 000 0 0040 f",
                     reqGnt, memEn, memAddr, memWReq);
        end
        nextCycle();
        reqAddr[16 +: 16]  = 16'h0044;
        reqWReq[4 +: 4]    = 4'b0000;
        reqWData[32 +: 32] = 32'h12345678;
        reqEn = 3'b010;
        #4;
        testsRun++;
        if (reqGnt !== 3'b010 || memWReq !== 4'b0000 || memWData !== 32'h12345678 || memAddr !== 16'h0044) begin
            testsFailed++;
            $display("[TB] FAIL single_write_issue: gnt=%b wreq=%h wdata=%h addr=%h expected 010 0 12345678 0044",
                     reqGnt, memWReq, memWData, memAddr);
        end
        nextCycle();
        reqEn = 3'b000;
        testsRun++;
        if (reqRvalid !== 3'b000) begin
            testsFailed++;
            $display("[TB] FAIL single_write_no_rvalid: got %b expected 000", reqRvalid);
        end
        reqWReq[4 +: 4] = 4'hF;
    endtask

    task automatic test_round_robin();
        logic [2:0]  expGnt [6];
        logic [31:0] expData [3];
        expGnt  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        expData = '{32'hDEAD0100, 32'hDEAD0101, 32'hDEAD0102};
        doReset();
        for (int i = 0; i < 3; i++) begin
            reqAddr[i*16 +: 16] = 16'h0100 + 16'(i);
            reqWReq[i*4 +: 4]   = 4'hF;
        end
        reqEn = 3'b111;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) begin
                testsRun++;
                if (reqRvalid !== expGnt[c-1] || reqRData !== expData[(c-1) % 3]) begin
                    testsFailed++;
                    $display("[TB] FAIL rr_rvalid[%0d]: rvalid=%b data=%h expected %b %h",
                             c, reqRvalid, reqRData, expGnt[c-1], expData[(c-1) % 3]);
                end
            end
            #4;
            testsRun++;
            if (reqGnt !== expGnt[c]) begin
                testsFailed++;
                $display("[TB] FAIL rr_gnt[%0d]: got %b expected %b", c, reqGnt, expGnt[c]);
            end
            nextCycle();
        end
        reqEn = 3'b000;
        testsRun++;
        if (reqRvalid !== 3'b100 || reqRData !== 32'hDEAD0102) begin
            testsFailed++;
            $display("[TB] FAIL rr_last_rvalid: rvalid=%b data=%h expected 100 dead0102", reqRvalid, reqRData);
        end
    endtask

    task automatic test_lock();
        doReset();
        reqEn   = 3'b100;
        reqLock = 3'b100;
        #4;
        testsRun++;
        if (reqGnt !== 3'b100) begin
            testsFailed++;
            $display("[TB] FAIL lock_gnt[0]: got %b expected 100", reqGnt);
        end
        nextCycle();
        reqEn = 3'b111;
        for (int c = 1; c < 5; c++) begin
            if (c == 4) reqLock = 3'b000;
            #4;
            testsRun++;
            if (reqGnt !== 3'b100) begin
                testsFailed++;
                $display("[TB] FAIL lock_gnt[%0d]: got %b expected 100", c, reqGnt);
            end
            nextCycle();
        end
        #4;
        testsRun++;
        if (reqGnt !== 3'b001) begin
            testsFailed++;
            $display("[TB] FAIL lock_release_gnt: got %b expected 001", reqGnt);
        end
        nextCycle();
        reqEn = 3'b000;
    endtask

    task automatic test_starvation();
        doReset();
        reqEn   = 3'b011;
        reqLock = 3'b001;
        for (int c = 0; c < 16; c++) begin
            #4;
            testsRun++;
            if (reqGnt !== 3'b001) begin
                testsFailed++;
                $display("[TB] FAIL burst_gnt[%0d]: got %b expected 001", c, reqGnt);
            end
            nextCycle();
        end
        #4;
        testsRun++;
        if (reqGnt !== 3'b010) begin
            testsFailed++;
            $display("[TB] FAIL burst_forced_release: got %b expected 010", reqGnt);
        end
        nextCycle();
        reqEn   = 3'b000;
        reqLock = 3'b000;
    endtask

    task automatic test_owner_drop();
        doReset();
        reqEn   = 3'b010;
        reqLock = 3'b010;
        #4;
        testsRun++;
        if (reqGnt !== 3'b010) begin
            testsFailed++;
            $display("[TB] FAIL drop_first_gnt: got %b expected 010", reqGnt);
        end
        nextCycle();
        reqEn = 3'b011;
        #4;
        testsRun++;
        if (reqGnt !== 3'b010) begin
            testsFailed++;
            $display("[TB] FAIL drop_locked_gnt: got %b expected 010", reqGnt);
        end
        nextCycle();
        reqEn = 3'b001;
        #4;
        testsRun++;
        if (reqGnt !== 3'b001 || memEn !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL drop_no_bubble: gnt=%b en=%b expected 001 1", reqGnt, memEn);
        end
        nextCycle();
        reqEn   = 3'b000;
        reqLock = 3'b000;
    endtask

    task automatic test_reset_midburst();
        doReset();
        reqAddr[0 +: 16] = 16'h0200;
        reqWReq[0 +: 4]  = 4'hF;
        reqEn   = 3'b001;
        reqLock = 3'b001;
        #4;
        testsRun++;
        if (reqGnt !== 3'b001) begin
            testsFailed++;
            $display("[TB] FAIL midrst_first_gnt: got %b expected 001", reqGnt);
        end
        nextCycle();
        rst = 1'b1;
        testsRun++;
        if (reqRvalid !== 3'b001 || reqRData !== 32'hDEAD0200) begin
            testsFailed++;
            $display("[TB] FAIL midrst_prior_rvalid: rvalid=%b data=%h expected 001 dead0200", reqRvalid, reqRData);
        end
        #4;
        testsRun++;
        if (reqGnt !== 3'b000 || memEn !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL midrst_gated: gnt=%b en=%b expected 000 0", reqGnt, memEn);
        end
        nextCycle();
        rst     = 1'b0;
        reqEn   = 3'b000;
        reqLock = 3'b000;
        testsRun++;
        if (reqRvalid !== 3'b000) begin
            testsFailed++;
            $display("[TB] FAIL midrst_rvalid_cleared: got %b expected 000", reqRvalid);
        end
        #4;
        testsRun++;
        if (reqGnt !== 3'b000 || memEn !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL midrst_idle: gnt=%b en=%b expected 000 0", reqGnt, memEn);
        end
        nextCycle();
        reqEn = 3'b010;
        #4;
        testsRun++;
        if (reqGnt !== 3'b010) begin
            testsFailed++;
            $display("[TB] FAIL midrst_after_010: got %b expected 010", reqGnt);
        end
        nextCycle();
        doReset();
        reqEn = 3'b011;
        #4;
        testsRun++;
        if (reqGnt !== 3'b001) begin
            testsFailed++;
            $display("[TB] FAIL midrst_after_011: got %b expected 001", reqGnt);
        end
        nextCycle();
        reqEn = 3'b000;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst      = 1'b1;
        reqEn    = 3'b000;
        reqLock  = 3'b000;
        reqAddr  = '0;
        reqWReq  = '1;
        reqWData = '0;
        memRData = '0;
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_starvation();
        test_owner_drop();
        test_reset_midburst();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/sp_ram_arbiter.md
Name: sp_ram_arbiter

Overview:
- Shares one single-port SRAM, the memory side of an sp_ram_intf, between NUM_REQ compute-side requesters (e.g. input-fetch, weight-fetch, output-writeback engines).
- Round-robin arbitration with an optional per-requester burst lock for row fetches.
- Bounded lock length to prevent starvation.
- Routes read-data-valid back to the requester that issued each read.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_W, 16, address width (matches ADDR_BUS_WIDTH).
- DATA_W, 32, data width (matches DATA_BUS_WIDTH).
- WREQ_W, 4, write-request width (matches W_REQ_WIDTH).
- MAX_BURST, 16, maximum consecutive locked grants to one requester (>=2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_en  in  NUM_REQ  per-requester access request.
- req_lock  in  NUM_REQ  keep grant on next cycle if still requesting.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W].
- req_W_req  in  NUM_REQ*WREQ_W  packed active-low byte write enables; all-ones means read.
- req_W_data  in  NUM_REQ*DATA_W  packed write data.
- req_gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as the access.
- req_rvalid  out  NUM_REQ  one-hot, registered; read data valid for requester i.
- req_R_data  out  DATA_W  read data broadcast to all requesters (= mem_R_data).
- mem_en  out  1  SRAM enable.
- mem_addr  out  ADDR_W  SRAM address.
- mem_W_req  out  WREQ_W  SRAM write enables.
- mem_W_data  out  DATA_W  SRAM write data.
- mem_R_data  in  DATA_W  SRAM read data, valid one cycle after a read with mem_en=1.

Behaviour:
- Reset: state=ARB, ptr=0, owner=0, burst_cnt=0, req_rvalid=0.
- While rst=1: req_gnt=0 and mem_en=0, gated combinationally.
- Access timing: a requester with req_gnt[i]=1 in cycle t has its access consumed at the clk edge ending t. mem_* carries requester i's fields in cycle t and mem_en=1.
- Idle: if no grant, mem_en=0, mem_W_req=all-ones, mem_addr and mem_W_data hold the last granted values.
- Read latency: if the access in cycle t had W_req all-ones, req_rvalid[i]=1 in cycle t+1 only. Writes never raise rvalid.
- Requesters may hold req_en across cycles. They sample req_gnt the same cycle and must not change fields while waiting.
- State ARB:
  - Winner = first i with req_en[i]=1 searching ptr, ptr+1, ... with wrap mod NUM_REQ.
  - On grant: ptr <= winner+1 mod NUM_REQ.
  - If req_lock[winner]=1 and MAX_BURST>1: state <= LOCK, owner <= winner, burst_cnt <= 1.
- State LOCK:
  - If req_en[owner]=1: grant owner only (others' gnt=0), burst_cnt <= burst_cnt+1.
  - Leave to ARB after this cycle if req_lock[owner]=0 or burst_cnt+1 == MAX_BURST.
  - If req_en[owner]=0: release with no bubble. Arbitrate this cycle exactly as ARB (ptr already owner+1), and the new winner may itself enter LOCK.
- Forced release at MAX_BURST: the owner's last access is granted; the next cycle's priority starts at owner+1, so any other pending requester wins before the owner.
- Simultaneous requests: exactly one grant per cycle; req_gnt is never multi-hot.
- burst_cnt width: clog2(MAX_BURST+1). No wrap possible since it is cleared on ARB entry.
- Reset mid-burst: takes effect at the next edge. Lock is dropped and a pending rvalid is cancelled (rvalid=0 in the cycle after rst).

Optional Feature:
- Macro: SP_RAM_ARB_PERF_EN.
- When defined, adds:
  - output perf_stall: NUM_REQ*32 bits, saturating per-requester counters of cycles with req_en=1 and req_gnt=0.
  - output perf_busy: 32 bits, saturating count of cycles with mem_en=1.
  - input perf_clr: clears all counters synchronously; takes priority over increments.
  - All counters reset to 0 on rst.
- When undefined: none of these ports or registers exist; behaviour is otherwise identical.

Test Plan:
- Single requester: req_en[1]=1 read at addr 0x0040 in cycle 5 -> gnt[1]=1, mem_addr=0x0040, mem_en=1 in cycle 5; rvalid[1]=1 in cycle 6 with req_R_data=mem_R_data; write with W_req=4'b0000 -> no rvalid.
- Round-robin: req_en=3'b111 held 6 cycles after reset -> grant sequence 0,1,2,0,1,2; rvalid follows each by one cycle.
- Lock: requester 2 holds req_en=1, req_lock=1 for 5 cycles while 0 and 1 request -> gnt[2] for 5 consecutive cycles; on req_lock drop, the next grant goes to 0.
- Starvation bound: requester 0 locked indefinitely, requester 1 pending, MAX_BURST=16 -> exactly 16 grants to 0, then gnt[1] next cycle.
- Owner drop in LOCK: owner 1 deasserts req_en with 0 pending -> gnt[0] the same cycle, no idle cycle.
- Reset mid-burst: rst=1 during a locked read -> in the next cycle rvalid=0, gnt=0, mem_en=0; after rst release with req_en=3'b010 -> gnt[1]; with 3'b011 -> gnt[0] (ptr=0).
